// File: rtl/slave_msg_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter over N_CH slave FIFOs. It frames each granted message as
// [SYNC, ADDR, LEN, payload..., (CHK)]. Define MSG_CHECKSUM_EN to append the CHK byte.
module slave_msg_arbiter #(
  parameter int         N_CH      = 5,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic                sys_clk,
  input  logic                n_rst,
  input  logic [N_CH-1:0]     have_msg_bus,
  input  logic [8*N_CH-1:0]   len_bus,
  input  logic [8*N_CH-1:0]   slave_data_bus,
  output logic [N_CH-1:0]     rdreq_bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy
);

  localparam int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0]   N_CH_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ADDR,
    S_LEN,
    S_PAYLOAD
`ifdef MSG_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [7:0]        len_lat;
  logic [7:0]        remain;
`ifdef MSG_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  logic              load_en;
  logic [N_CH-1:0]   elig;
  logic [2*N_CH-1:0] elig_dbl;
  logic [N_CH-1:0]   elig_rot;
  logic              found;
  logic [CH_W-1:0]   offset;
  logic [CH_W:0]     pick_sum;
  logic [CH_W-1:0]   pick;
  logic [7:0]        pick_len;
  logic [7:0]        head_byte;
  logic [7:0]        addr_byte;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  // A new byte may enter the output register whenever it is empty or draining.
  assign load_en   = !tx_valid || tx_ready;
  assign addr_byte = 8'(ch);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = have_msg_bus[i] && (len_bus[i*8 +: 8] != 8'd0);
    end
  end

  // Rotating the request vector by rr_ptr turns round-robin into a plain
  // lowest-index priority search.
  assign elig_dbl = {elig, elig} >> rr_ptr;
  assign elig_rot = elig_dbl[N_CH-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        found  = 1'b1;
        offset = CH_W'(k);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign pick     = (pick_sum >= N_CH_EXT) ? CH_W'(pick_sum - N_CH_EXT)
                                           : pick_sum[CH_W-1:0];

  always_comb begin
    pick_len  = 8'd0;
    head_byte = 8'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick == CH_W'(i)) pick_len  = len_bus[i*8 +: 8];
      if (ch   == CH_W'(i)) head_byte = slave_data_bus[i*8 +: 8];
    end
  end

  // The pop happens on the edge that captures the show-ahead head byte, so
  // back-to-back loads never see a stale head.
  always_comb begin
    rdreq_bus = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((state == S_PAYLOAD) && load_en && (ch == CH_W'(i))) rdreq_bus[i] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      ch       <= '0;
      rr_ptr   <= '0;
      len_lat  <= 8'd0;
      remain   <= 8'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef MSG_CHECKSUM_EN
      chk_acc  <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // The previous frame's last byte may still be waiting in the output register.
          if (tx_valid && tx_ready) tx_valid <= 1'b0;
          if (found) begin
            ch      <= pick;
            len_lat <= pick_len;
            rr_ptr  <= ch_inc(pick);
            busy    <= 1'b1;
            state   <= S_SYNC;
`ifdef MSG_CHECKSUM_EN
            chk_acc <= 8'd0;
`endif
          end else begin
            busy <= tx_valid && !tx_ready;
          end
        end
        S_SYNC: begin
          if (load_en) begin
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (load_en) begin
            tx_data  <= addr_byte;
            tx_valid <= 1'b1;
            state    <= S_LEN;
`ifdef MSG_CHECKSUM_EN
            chk_acc  <= chk_acc ^ addr_byte;
`endif
          end
        end
        S_LEN: begin
          if (load_en) begin
            tx_data  <= len_lat;
            tx_valid <= 1'b1;
            remain   <= len_lat;
            state    <= S_PAYLOAD;
`ifdef MSG_CHECKSUM_EN
            chk_acc  <= chk_acc ^ len_lat;
`endif
          end
        end
        S_PAYLOAD: begin
          if (load_en) begin
            tx_data  <= head_byte;
            tx_valid <= 1'b1;
            remain   <= remain - 8'd1;
`ifdef MSG_CHECKSUM_EN
            chk_acc  <= chk_acc ^ head_byte;
            if (remain == 8'd1) state <= S_CHK;
`else
            if (remain == 8'd1) state <= S_IDLE;
`endif
          end
        end
`ifdef MSG_CHECKSUM_EN
        S_CHK: begin
          if (load_en) begin
            tx_data  <= chk_acc;
            tx_valid <= 1'b1;
            state    <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
